// File: rtl/diffusion_stage_reg.sv
// rtl/diffusion_stage_reg.sv - ASCON linear diffusion layer (p_L) with registered valid/ready output
//
// Ports:
//   clock_i      in   system clock, rising edge
//   resetb_i     in   asynchronous active-low reset
//   registerS_i  in   substituted state, word k = registerS_i[k], bit 63 = MSB
//   valid_i      in   registerS_i/last_i valid
//   last_i       in   final round of the current permutation
//   ready_o      out  stage can accept this cycle
//   registerS_o  out  diffused state
//   valid_o      out  registerS_o/last_o valid
//   last_o       out  last_i travelling with its data
//   ready_i      in   downstream accepts this cycle
//
// SKID_EN=1 adds a one-entry skid register so ready_o comes straight from a flop;
// SKID_EN=0 uses a single output register and a combinational ready_o.

module diffusion_stage_reg #(
  parameter int SKID_EN = 1
) (
  input  logic            clock_i,
  input  logic            resetb_i,
  input  logic [4:0][63:0] registerS_i,
  input  logic            valid_i,
  input  logic            last_i,
  output logic            ready_o,
  output logic [4:0][63:0] registerS_o,
  output logic            valid_o,
  output logic            last_o,
  input  logic            ready_i
);

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  logic [4:0][63:0] diffused;
  logic [4:0][63:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             accept;

  always_comb begin
    diffused    = '0;
    diffused[0] = registerS_i[0] ^ rotr(registerS_i[0], 19) ^ rotr(registerS_i[0], 28);
    diffused[1] = registerS_i[1] ^ rotr(registerS_i[1], 61) ^ rotr(registerS_i[1], 39);
    diffused[2] = registerS_i[2] ^ rotr(registerS_i[2], 1)  ^ rotr(registerS_i[2], 6);
    diffused[3] = registerS_i[3] ^ rotr(registerS_i[3], 10) ^ rotr(registerS_i[3], 17);
    diffused[4] = registerS_i[4] ^ rotr(registerS_i[4], 7)  ^ rotr(registerS_i[4], 41);
  end

  assign accept      = valid_i & ready_o;
  assign registerS_o = out_data;
  assign valid_o     = out_valid;
  assign last_o      = out_last;

  if (SKID_EN != 0) begin : g_skid
    logic [4:0][63:0] skid_data;
    logic             skid_last;
    logic             skid_full;

    // skid_full is a flop, so ready_o carries no combinational path from ready_i
    assign ready_o = ~skid_full;

    always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
        out_data  <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        skid_data <= '0;
        skid_last <= 1'b0;
        skid_full <= 1'b0;
      end else begin
        if (!out_valid || ready_i) begin
          // Output slot frees up: the older skid entry always goes first
          if (skid_full) begin
            out_data  <= skid_data;
            out_last  <= skid_last;
            out_valid <= 1'b1;
            skid_full <= 1'b0;
          end else if (accept) begin
            out_data  <= diffused;
            out_last  <= last_i;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (accept) begin
          // Output stalled: park the word that was accepted under the old ready
          skid_data <= diffused;
          skid_last <= last_i;
          skid_full <= 1'b1;
        end
      end
    end
  end else begin : g_noskid
    assign ready_o = ~out_valid | ready_i;

    always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
        out_data  <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        if (accept) begin
          out_data  <= diffused;
          out_last  <= last_i;
          out_valid <= 1'b1;
        end else if (ready_i) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_diffusion_stage_reg.sv
// tb/tb_diffusion_stage_reg.sv - self-checking bench for diffusion_stage_reg, both SKID_EN settings

module tb_diffusion_stage_reg;

  logic             clock_i = 1'b0;
  logic             resetb_i;
  logic [4:0][63:0] registerS_i;
  logic             valid_i;
  logic             last_i;
  logic             ready_i;

  logic             s_ready, s_valid, s_last;
  logic [4:0][63:0] s_data;
  logic             n_ready, n_valid, n_last;
  logic [4:0][63:0] n_data;

  int tests = 0;
  int fails = 0;
  int cnt_s = 0;
  int cnt_n = 0;

  logic [320:0] q_s[$];
  logic [320:0] q_n[$];

  always #5 clock_i = ~clock_i;

  diffusion_stage_reg #(.SKID_EN(1)) dut_s (
    .clock_i(clock_i), .resetb_i(resetb_i), .registerS_i(registerS_i),
    .valid_i(valid_i), .last_i(last_i), .ready_o(s_ready),
    .registerS_o(s_data), .valid_o(s_valid), .last_o(s_last), .ready_i(ready_i)
  );

  diffusion_stage_reg #(.SKID_EN(0)) dut_n (
    .clock_i(clock_i), .resetb_i(resetb_i), .registerS_i(registerS_i),
    .valid_i(valid_i), .last_i(last_i), .ready_o(n_ready),
    .registerS_o(n_data), .valid_o(n_valid), .last_o(n_last), .ready_i(ready_i)
  );

  function automatic int rot_a(input int k);
    case (k)
      0: return 19; 1: return 61; 2: return 1; 3: return 10; default: return 7;
    endcase
  endfunction

  function automatic int rot_b(input int k);
    case (k)
      0: return 28; 1: return 39; 2: return 6; 3: return 17; default: return 41;
    endcase
  endfunction

  // Bit i of rotr(x,r) is bit (i+r) mod 64 of x
  function automatic logic [4:0][63:0] ref_pl(input logic [4:0][63:0] s);
    logic [4:0][63:0] y;
    y = '0;
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 64; i++)
        y[k][i] = s[k][i] ^ s[k][(i + rot_a(k)) % 64] ^ s[k][(i + rot_b(k)) % 64];
    return y;
  endfunction

  function automatic logic [4:0][63:0] rnd_state();
    logic [4:0][63:0] s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic check(input string tag, input logic [320:0] obs, input logic [320:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, score the coming edge, return at next negedge
  task automatic cycle(input bit v, input logic [4:0][63:0] d, input bit l, input bit r,
                       output bit acc_s);
    logic [320:0] e;
    valid_i = v; registerS_i = d; last_i = l; ready_i = r;
    #1;
    if (s_valid && ready_i) begin
      check("skid_pending", 321'(q_s.size() > 0), 321'(1));
      if (q_s.size() > 0) begin e = q_s.pop_front(); check("skid_out", {s_last, s_data}, e); end
      cnt_s++;
    end
    if (n_valid && ready_i) begin
      check("noskid_pending", 321'(q_n.size() > 0), 321'(1));
      if (q_n.size() > 0) begin e = q_n.pop_front(); check("noskid_out", {n_last, n_data}, e); end
      cnt_n++;
    end
    acc_s = v && s_ready;
    if (v && s_ready) q_s.push_back({l, ref_pl(d)});
    if (v && n_ready) q_n.push_back({l, ref_pl(d)});
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic drain(input string tag);
    bit a;
    repeat (6) cycle(1'b0, '0, 1'b0, 1'b1, a);
    check({tag, "_skid_empty"}, 321'(q_s.size()), 321'(0));
    check({tag, "_noskid_empty"}, 321'(q_n.size()), 321'(0));
  endtask

  initial begin
    bit acc;
    int idx;
    logic [4:0][63:0] items[4];
    logic [4:0][63:0] st;
    logic [4:0][63:0] exp1;

    resetb_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0; registerS_i = '0;
    #22;
    check("rst_valid", {s_valid, n_valid}, 321'(0));
    check("rst_last", {s_last, n_last}, 321'(0));
    check("rst_data_s", 321'(s_data), 321'(0));
    check("rst_data_n", 321'(n_data), 321'(0));
    check("rst_ready", {s_ready, n_ready}, 321'(3));
    @(negedge clock_i);
    resetb_i = 1'b1;

    // Single known vector
    exp1[0] = 64'h0000_2010_0000_0001;
    exp1[1] = 64'h0000_0000_0200_0009;
    exp1[2] = 64'h8400_0000_0000_0001;
    exp1[3] = 64'h0040_8000_0000_0001;
    exp1[4] = 64'h0200_0000_0080_0001;
    st = {5{64'h1}};
    cycle(1'b1, st, 1'b0, 1'b1, acc);
    check("vec1_valid", {s_valid, n_valid}, 321'(3));
    check("vec1_data_s", 321'(s_data), 321'(exp1));
    check("vec1_data_n", 321'(n_data), 321'(exp1));
    cycle(1'b1, '0, 1'b0, 1'b1, acc);
    check("zero_data_s", 321'(s_data), 321'(0));
    cycle(1'b1, '1, 1'b1, 1'b1, acc);
    check("ones_data_s", {s_last, s_data}, {1'b1, {320{1'b1}}});
    check("ones_data_n", {n_last, n_data}, {1'b1, {320{1'b1}}});
    drain("basic");

    // Back-pressure: A..D, downstream stalls for 3 cycles after A
    for (int i = 0; i < 4; i++) items[i] = rnd_state();
    idx = 0; cnt_s = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) check("bp_ready_before_skid", 321'(s_ready), 321'(1));
      if (c == 2) check("bp_ready_skid_full", 321'(s_ready), 321'(0));
      cycle(idx < 4, (idx < 4) ? items[idx] : '0, idx == 3, !(c >= 1 && c <= 3), acc);
      if (acc) idx++;
    end
    check("bp_all_sent", 321'(idx), 321'(4));
    check("bp_out_count", 321'(cnt_s), 321'(4));
    drain("bp");

    // Throughput: 16 back-to-back with ready_i held high
    for (int t = 0; t < 17; t++) begin
      cycle(t < 16, rnd_state(), 1'b0, 1'b1, acc);
      if (t < 16) check("tput_valid", {s_valid, n_valid}, 321'(3));
      else check("tput_done", {s_valid, n_valid}, 321'(0));
    end
    drain("tput");

    // Asynchronous reset with output and skid full
    st = rnd_state();
    cycle(1'b1, st, 1'b0, 1'b0, acc);
    cycle(1'b1, rnd_state(), 1'b1, 1'b0, acc);
    check("mid_skid_full", 321'(s_ready), 321'(0));
    #2 resetb_i = 1'b0;
    #1;
    check("arst_valid", {s_valid, n_valid}, 321'(0));
    check("arst_data_s", 321'(s_data), 321'(0));
    check("arst_data_n", 321'(n_data), 321'(0));
    check("arst_ready_s", 321'(s_ready), 321'(1));
    q_s.delete(); q_n.delete();
    @(negedge clock_i);
    resetb_i = 1'b1;
    cnt_s = 0; cnt_n = 0;
    cycle(1'b1, rnd_state(), 1'b1, 1'b1, acc);
    drain("post_rst");
    check("post_rst_count", {cnt_s[15:0], cnt_n[15:0]}, {16'd1, 16'd1});

    // Random traffic
    for (int i = 0; i < 10000; i++)
      cycle($urandom_range(0, 3) != 0, rnd_state(), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) != 0, acc);
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/diffusion_stage_reg.md
Name: diffusion_stage_reg

Overview:
- Linear diffusion layer (p_L) of the ASCON permutation, placed directly downstream of the 64-column substitution layer.
- Consumes the substituted type_state (5 x 64-bit words), applies the per-word XOR-of-rotations, and registers the result behind a valid/ready handshake.
- Optional skid buffer gives full throughput with a registered ready.
- A last-round sideband flag travels alongside the data so the round sequencer downstream can detect permutation end.

Parameters:
- SKID_EN, 1: 1 = two-entry skid buffer with registered ready_o; 0 = single output register with combinational ready_o.

Ports:
- clock_i  in  1  system clock, rising edge
- resetb_i  in  1  asynchronous, active-low reset
- registerS_i  in  type_state (5x64)  substituted state from substitution layer
- valid_i  in  1  registerS_i/last_i valid
- last_i  in  1  marks final round of current permutation
- ready_o  out  1  stage can accept this cycle
- registerS_o  out  type_state (5x64)  diffused state
- valid_o  out  1  registerS_o/last_o valid
- last_o  out  1  last_i delayed with its data
- ready_i  in  1  downstream accepts this cycle

Behaviour:
- Reset (resetb_i low, asynchronous): valid_o=0, last_o=0, registerS_o=all zero, skid entry empty, ready_o=1 (SKID_EN=1) or ready_o=1 via logic (SKID_EN=0). Reset mid-transfer discards all held data; no partial state survives.
- Diffusion (rotr = rotate right, 64 bits):
  - x0 ^= rotr(x0,19) ^ rotr(x0,28)
  - x1 ^= rotr(x1,61) ^ rotr(x1,39)
  - x2 ^= rotr(x2,1) ^ rotr(x2,6)
  - x3 ^= rotr(x3,10) ^ rotr(x3,17)
  - x4 ^= rotr(x4,7) ^ rotr(x4,41)
  - Word index k = registerS_i[k]; bit 63 = MSB. Purely combinational before the output register.
- Transfer rules:
  - Input accepted when valid_i & ready_o.
  - Output consumed when valid_o & ready_i.
  - Latency: 1 clock from accept to valid_o.
  - registerS_o/last_o stable while valid_o=1 and ready_i=0.
- SKID_EN=0:
  - ready_o = !valid_o | ready_i.
  - Output register loads on accept.
  - valid_o clears on consume without simultaneous accept.
  - Simultaneous consume+accept: reload, valid_o stays 1. Back-to-back throughput = 1/cycle.
- SKID_EN=1:
  - ready_o = !skid_full, registered.
  - Accept while output stalled (valid_o=1, ready_i=0) stores into skid entry; ready_o drops next cycle.
  - On consume, skid entry (if full) moves to output register and ready_o rises next cycle; otherwise output loads directly from the input.
  - Never drops or reorders data; full throughput when ready_i held 1.
- valid_i without ready_o: nothing captured; upstream holds.
- No combinational path from valid_i to valid_o. Combinational path ready_i to ready_o exists only when SKID_EN=0.

Test Plan:
- Single vector: registerS_i all words 64'h1, valid_i=1, ready_i=1 -> next cycle valid_o=1 with:
  - x0=64'h0000_2010_0000_0001
  - x1=64'h0000_0000_0200_0009
  - x2=64'h8400_0000_0000_0001
  - x3=64'h0040_8000_0000_0001
  - x4=64'h0200_0000_0080_0001
- Zero state: all-zero input -> all-zero output. All-ones input -> all-ones output (odd number of ones XORed per bit).
- Back-pressure (SKID_EN=1): stream 4 states A..D with last_i on D. Hold ready_i=0 for 3 cycles after A accepted -> ready_o falls after one extra accept (B in skid). Output sequence A,B,C,D in order, last_o=1 only with D, no loss.
- Throughput: ready_i=1, valid_i=1 for 16 cycles, both SKID_EN values -> 16 outputs on 16 consecutive cycles after 1-cycle latency.
- Reset mid-operation: assert resetb_i low asynchronously while output and skid are full -> valid_o=0, registerS_o=0 immediately, without a clock edge. After release, first accepted state appears alone; stale data never reappears.
- Random: 10k random states with random valid_i/ready_i -> scoreboard vs reference p_L model, order and last flags match.
